serial_to_parallel_receiver: RTL and testbench
==============================================

// Module: serial_to_parallel_receiver
// PURPOSE
//  Downstream consumer of the parallel-to-serial stage: reassembles the serial bit stream into N-bit words.
//  Counts bits, shifts them in MSB_FIRST or LSB_FIRST order, and presents each completed word on a valid/ready output.
//  Double-buffered: the shifter keeps collecting the next frame while the previous word waits for the consumer.
//  Reports overrun when a frame completes while the output word is still unconsumed.
// PARAMETERS
//  N   4   word width in bits; legal range N >= 2
// PORTS
//  clk           input   1    single clock; all state updates on posedge clk
//  rst           input   1    synchronous, active-high reset
//  i_bit_valid   input   1    i_bit is a live stream bit this cycle
//  i_bit         input   1    serial data bit
//  direction     input   1    shift_direction_t (MSB_FIRST=0, LSB_FIRST=1); sampled on the first bit of each frame
//  i_ready       input   1    consumer accepts o_data when o_valid & i_ready
//  o_data        output  N    assembled word
//  o_valid       output  1    o_data holds an unconsumed word
//  o_busy        output  1    a frame is partially received (bit count != 0)
//  o_overrun     output  1    sticky; a completed frame was dropped; cleared only by rst
//  o_parity_err  output  1    parity result for o_data; constant 0 when PARITY_CHECK_EN is undefined
// BEHAVIOUR
//  Reset: o_data=0, o_valid=0, o_busy=0, o_overrun=0, o_parity_err=0, shifter=0, count=0, FSM=S_IDLE.
//  Reset mid-frame discards the partial frame and any held word.
//  FSM states: S_IDLE (count==0), S_SHIFT (collecting data bits), S_PARITY (only with PARITY_CHECK_EN).
//  S_IDLE + i_bit_valid: latch direction into dir_q, shift in bit, count=1, go to S_SHIFT.
//  S_SHIFT + i_bit_valid, MSB_FIRST: sh <= {sh[N-2:0], i_bit}.
//  S_SHIFT + i_bit_valid, LSB_FIRST: sh <= {i_bit, sh[N-1:1]}.
//  S_SHIFT: count increments per accepted bit. On the Nth bit the frame completes and the FSM returns to S_IDLE.
//  With PARITY_CHECK_EN, the FSM goes to S_PARITY after the Nth bit instead.
//  i_bit_valid=0 stalls: no shift, no count change, in any state.
//  Completion: assembled word is loaded into o_data on the same edge that accepts the last bit.
//  o_valid is high from the next cycle, so latency is 1 cycle from the last bit to o_valid.
//  Handshake: o_valid, o_data and o_parity_err stay stable until o_valid & i_ready; o_valid clears on the next edge.
//  Completion with o_valid=0, or with o_valid & i_ready in the same cycle: load the new word, o_valid=1, no overrun.
//  Completion with o_valid=1 & i_ready=0: drop the new word, keep the old one, set o_overrun=1.
//  Back-to-back frames with no gap are legal. The count wraps to 0 at completion; counter width is $clog2(N+1).
//  A direction change mid-frame has no effect until the next frame.
//  o_busy = (count != 0) || (state == S_PARITY).
// CONFIGURATION
//  PARITY_CHECK_EN defined: each frame carries N data bits plus 1 trailing even-parity bit, accepted in S_PARITY.
//    At completion: o_parity_err <= ^{data, parity_bit}. The word is still delivered and subject to the overrun rules.
//  PARITY_CHECK_EN undefined: frames are exactly N bits, S_PARITY does not exist, o_parity_err is tied to 0.
// STRUCTURE
//  Package serial_pkg:
//    shift_direction_t enum {MSB_FIRST, LSB_FIRST} (replaces the per-file enum; the serializer imports it too).
//    rx_state_t enum {S_IDLE, S_SHIFT, S_PARITY}.
//  One sub-module, serial_shift_in #(N): the shifter and bit counter, with ports clk, rst, en, bit, dir, word, count.
//  The top level holds the FSM, output register, handshake and overrun logic.
// TESTING (N=4)
//  1. MSB_FIRST bits 1,0,1,1 on consecutive cycles, i_ready=1 -> o_data=4'b1011, o_valid high for exactly 1 cycle, 1 cycle after the 4th bit.
//  2. LSB_FIRST bits 1,0,1,1 -> o_data=4'b1101; i_bit_valid gaps of 0-3 cycles between bits give the same result.
//  3. i_ready=0, two back-to-back frames 4'hA then 4'h5 -> o_data stays 4'hA, o_overrun=1 sticky.
//     Then i_ready=1 -> 4'hA consumed, 4'h5 is never seen.
//  4. i_ready pulsed on the same cycle the 2nd frame completes -> 4'hA accepted, o_data=4'h5, o_valid stays 1, o_overrun=0.
//  5. rst asserted after 2 of 4 bits -> all outputs 0; the next 4 bits 0,1,1,0 (MSB_FIRST) -> o_data=4'h6.
//  6. [PARITY_CHECK_EN] bits 1,0,1,1 + parity 1 -> o_data=4'hB, o_parity_err=0.
//     Bits 1,0,1,1 + parity 0 -> o_data=4'hB, o_parity_err=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the serial link: shift direction and receiver FSM states.
package serial_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } shift_direction_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } rx_state_t;

    // Bit counter width able to hold 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Shift register and bit counter for the serial receiver.
// Direction is latched on the first bit of a frame and held for the rest of it.
// word_c is the shifter's next value, so the caller can capture a word on the
// same edge that accepts its last bit.
module serial_shift_in
    import serial_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned CNT_W = cnt_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  shift_direction_t dir,
    output logic [N-1:0]     word_c,
    output logic [CNT_W-1:0] count
);

    logic [N-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0] count_q, count_d;
    shift_direction_t dir_q, dir_d;
    shift_direction_t dir_eff;

    // Next shifter/counter state; the first bit of a frame uses the live direction
    always_comb begin
        sh_d    = sh_q;
        count_d = count_q;
        dir_d   = dir_q;
        dir_eff = (count_q == '0) ? dir : dir_q;
        if (en) begin
            if (count_q == '0) begin
                dir_d = dir;
            end
            if (dir_eff == MSB_FIRST) begin
                sh_d = {sh_q[N-2:0], bit_in};
            end else begin
                sh_d = {bit_in, sh_q[N-1:1]};
            end
            count_d = (count_q == CNT_W'(N - 1)) ? '0 : count_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            count_q <= '0;
            dir_q   <= MSB_FIRST;
        end else begin
            sh_q    <= sh_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    assign word_c = sh_d;
    assign count  = count_q;

endmodule

// File: rtl/serial_to_parallel_receiver.sv
// Reassembles a serial bit stream into N-bit words on a valid/ready output.
// The shifter keeps collecting while a finished word waits for the consumer;
// a frame that completes into an occupied, unaccepted output is dropped and
// flagged by the sticky o_overrun.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit
// per frame and drives o_parity_err; otherwise o_parity_err is tied low).
module serial_to_parallel_receiver
    import serial_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    input  shift_direction_t direction,
    input  logic             i_ready,
    output logic [N-1:0]     o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_parity_err
);

    localparam int unsigned CNT_W = cnt_width(N);

    rx_state_t        state_q, state_d;
    logic [N-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             shift_en_c;
    logic             frame_done_c;
    logic [N-1:0]     word_c;
    logic [CNT_W-1:0] count;
`ifdef PARITY_CHECK_EN
    logic             perr_q, perr_d;
    logic             new_perr_c;
`endif

    // Data bits shift only outside the parity slot
    assign shift_en_c = i_bit_valid && (state_q != S_PARITY);

    serial_shift_in #(.N(N)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .en     (shift_en_c),
        .bit_in (i_bit),
        .dir    (direction),
        .word_c (word_c),
        .count  (count)
    );

    // Frame FSM, output holding register, handshake and overrun
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        frame_done_c = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_d       = perr_q;
        new_perr_c   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_bit_valid) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_bit_valid && (count == CNT_W'(N - 1))) begin
`ifdef PARITY_CHECK_EN
                    state_d = S_PARITY;
`else
                    state_d      = S_IDLE;
                    frame_done_c = 1'b1;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (i_bit_valid) begin
                    state_d      = S_IDLE;
                    frame_done_c = 1'b1;
                    new_perr_c   = ^{word_c, i_bit};
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (frame_done_c) begin
            if (!valid_q || i_ready) begin
                data_d  = word_c;
                valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d  = new_perr_c;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_overrun = overrun_q;
`ifdef PARITY_CHECK_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Bench for serial_to_parallel_receiver (N=4): a frame-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_serial_to_parallel_receiver;
    import serial_pkg::*;

    localparam int unsigned N = 4;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME = N + 1;
`else
    localparam int unsigned FRAME = N;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_bit_valid = 1'b0;
    logic             i_bit = 1'b0;
    logic             i_ready = 1'b0;
    shift_direction_t direction = MSB_FIRST;
    logic [N-1:0]     o_data;
    logic             o_valid, o_busy, o_overrun, o_parity_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_to_parallel_receiver #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_bit_valid  (i_bit_valid),
        .i_bit        (i_bit),
        .direction    (direction),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects frame bits in a list, builds the word by weight
    int               m_bits[$];
    shift_direction_t m_dir = MSB_FIRST;
    logic             m_valid = 1'b0;
    logic [N-1:0]     m_data = '0;
    logic             m_overrun = 1'b0;
    logic             m_perr = 1'b0;
    logic [N-1:0]     accepted[$];

    always @(posedge clk) begin
        if (rst) begin
            m_bits.delete();
            m_valid   = 1'b0;
            m_data    = '0;
            m_overrun = 1'b0;
            m_perr    = 1'b0;
        end else begin
            logic         done;
            logic         was_valid;
            logic         p;
            int           val;
            int           ones;
            done      = 1'b0;
            was_valid = m_valid;
            val       = 0;
            ones      = 0;
            p         = 1'b0;
            if (m_valid && i_ready) begin
                accepted.push_back(m_data);
                m_valid = 1'b0;
            end
            if (i_bit_valid) begin
                if (m_bits.size() == 0) m_dir = direction;
                m_bits.push_back(i_bit ? 1 : 0);
                if (m_bits.size() == FRAME) begin
                    for (int i = 0; i < int'(N); i++) begin
                        val  += m_bits[i] * (1 << ((m_dir == MSB_FIRST) ? (int'(N) - 1 - i) : i));
                        ones += m_bits[i];
                    end
`ifdef PARITY_CHECK_EN
                    ones += m_bits[N];
                    p = (ones % 2) != 0;
`endif
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            if (done) begin
                if (!was_valid || i_ready) begin
                    m_data  = N'(val);
                    m_valid = 1'b1;
                    m_perr  = p;
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("cyc_valid",   32'(o_valid),      32'(m_valid));
        chk("cyc_data",    32'(o_data),       32'(m_data));
        chk("cyc_busy",    32'(o_busy),       32'(m_bits.size() != 0));
        chk("cyc_overrun", 32'(o_overrun),    32'(m_overrun));
        chk("cyc_perr",    32'(o_parity_err), 32'(m_perr));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input shift_direction_t d);
        i_bit_valid = 1'b1;
        i_bit       = b;
        direction   = d;
        step();
        i_bit_valid = 1'b0;
    endtask

    // Sends seq[N-1] first; par is the trailing parity bit when enabled
    task automatic send_frame(input logic [N-1:0] seq, input shift_direction_t d,
                              input int gap, input logic par, input logic rdy_last);
        logic last;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            last = (FRAME == N) && (i == 0);
            if (last && rdy_last) i_ready = 1'b1;
            send(seq[i], d);
            if (last && rdy_last) i_ready = 1'b0;
            if (!last) begin
                for (int g = 0; g < gap; g++) begin
                    i_bit = ~i_bit;
                    step();
                end
            end
        end
`ifdef PARITY_CHECK_EN
        if (rdy_last) i_ready = 1'b1;
        send(par, d);
        if (rdy_last) i_ready = 1'b0;
`else
        if (par) i_bit = 1'b0;
`endif
    endtask

    initial begin
        step();
        step();
        chk("reset_valid", 32'(o_valid), 32'h0);
        chk("reset_data",  32'(o_data),  32'h0);
        rst = 1'b0;
        step();

        // MSB-first 1,0,1,1 with consumer ready
        i_ready = 1'b1;
        send_frame(4'b1011, MSB_FIRST, 0, 1'b1, 1'b0);
        chk("t1_data",  32'(o_data),  32'hB);
        chk("t1_valid", 32'(o_valid), 32'h1);
        step();
        chk("t1_valid_drop", 32'(o_valid), 32'h0);

        // LSB-first 1,0,1,1 with 0..3 idle cycles between bits
        for (int g = 0; g < 4; g++) begin
            send_frame(4'b1011, LSB_FIRST, g, 1'b1, 1'b0);
            chk("t2_data",  32'(o_data),  32'hD);
            chk("t2_valid", 32'(o_valid), 32'h1);
            step();
        end

        // Two back-to-back frames while the consumer stalls
        i_ready = 1'b0;
        send_frame(4'hA, MSB_FIRST, 0, 1'b0, 1'b0);
        chk("t3_first_valid", 32'(o_valid),   32'h1);
        chk("t3_no_overrun",  32'(o_overrun), 32'h0);
        send_frame(4'h5, MSB_FIRST, 0, 1'b0, 1'b0);
        chk("t3_data_held", 32'(o_data),    32'hA);
        chk("t3_overrun",   32'(o_overrun), 32'h1);
        step();
        step();
        chk("t3_overrun_sticky", 32'(o_overrun), 32'h1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("t3_consumed",      32'(o_valid),   32'h0);
        chk("t3_data_not_5",    32'(o_data),    32'hA);
        chk("t3_overrun_kept",  32'(o_overrun), 32'h1);
        chk("t3_model_accept",  32'(accepted[accepted.size()-1]), 32'hA);
        step();
        chk("t3_nothing_new", 32'(o_valid), 32'h0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_overrun", 32'(o_overrun), 32'h0);

        // Ready pulsed on the cycle the second frame completes
        send_frame(4'hA, MSB_FIRST, 0, 1'b0, 1'b0);
        send_frame(4'h5, MSB_FIRST, 0, 1'b0, 1'b1);
        chk("t4_data",    32'(o_data),    32'h5);
        chk("t4_valid",   32'(o_valid),   32'h1);
        chk("t4_overrun", 32'(o_overrun), 32'h0);
        chk("t4_model_accept", 32'(accepted[accepted.size()-1]), 32'hA);
        i_ready = 1'b1;
        step();
        chk("t4_consumed", 32'(o_valid), 32'h0);

        // Reset mid-frame, then a clean frame
        send(1'b1, MSB_FIRST);
        send(1'b1, MSB_FIRST);
        chk("t5_busy", 32'(o_busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_data",    32'(o_data),       32'h0);
        chk("t5_rst_valid",   32'(o_valid),      32'h0);
        chk("t5_rst_busy",    32'(o_busy),       32'h0);
        chk("t5_rst_overrun", 32'(o_overrun),    32'h0);
        chk("t5_rst_perr",    32'(o_parity_err), 32'h0);
        send_frame(4'b0110, MSB_FIRST, 0, 1'b0, 1'b0);
        chk("t5_data", 32'(o_data), 32'h6);
        step();

        // Direction changes after the first bit are ignored for that frame
        send(1'b1, MSB_FIRST);
        send(1'b1, LSB_FIRST);
        send(1'b0, LSB_FIRST);
        send(1'b0, LSB_FIRST);
`ifdef PARITY_CHECK_EN
        send(1'b0, LSB_FIRST);
`endif
        chk("dir_latched", 32'(o_data), 32'hC);
        step();

`ifdef PARITY_CHECK_EN
        // Good and bad parity
        send_frame(4'b1011, MSB_FIRST, 0, 1'b1, 1'b0);
        chk("t6_good_data", 32'(o_data),       32'hB);
        chk("t6_good_perr", 32'(o_parity_err), 32'h0);
        step();
        send_frame(4'b1011, MSB_FIRST, 0, 1'b0, 1'b0);
        chk("t6_bad_data", 32'(o_data),       32'hB);
        chk("t6_bad_perr", 32'(o_parity_err), 32'h1);
        chk("t6_bad_valid", 32'(o_valid),     32'h1);
        step();
`else
        chk("perr_tied", 32'(o_parity_err), 32'h0);
`endif

        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
